// File: rtl/envelope_sequencer.sv
// rtl/envelope_sequencer.sv - gate-driven ADSR phase/step sequencer for the envelope gain stage
//
// Purpose: tracks the ADSR phase and gain-step index of one note. All state
// advances only on codec sample ticks, so phase durations are counted in samples.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   sample_tick  one-cycle codec sample request; only these cycles advance state
//   gate         note gate level (1 = key held), sampled on sample_tick
//   phase        0 IDLE, 1 ATTACK, 2 DECAY, 3 SUSTAIN, 4 RELEASE
//   step         gain-step index within the current phase
//   active       1 whenever phase != IDLE
//   out_ready    sample_tick delayed one clock, aligned with phase/step
//   note_done    one-cycle pulse when RELEASE finishes into IDLE
`timescale 1ns/1ps

module envelope_sequencer #(
  parameter int STEP_LEN = 480,
  parameter int A_STEPS  = 10,
  parameter int D_STEPS  = 10,
  parameter int R_STEPS  = 10,
  parameter int CNT_W    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_tick,
  input  logic       gate,
  output logic [2:0] phase,
  output logic [3:0] step,
  output logic       active,
  output logic       out_ready,
  output logic       note_done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } phase_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_LEN - 1);
  localparam logic [3:0]       A_LAST   = 4'(A_STEPS - 1);
  localparam logic [3:0]       D_LAST   = 4'(D_STEPS - 1);
  localparam logic [3:0]       R_LAST   = 4'(R_STEPS - 1);

  phase_t           phase_q, phase_d;
  logic [3:0]       step_q, step_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gate_q;
  logic             done_d;
  logic             rise, fall, legal;
  logic [3:0]       last_step;

  assign phase = phase_q;
  assign step  = step_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q   <= IDLE;
      step_q    <= '0;
      cnt_q     <= '0;
      gate_q    <= 1'b0;
      active    <= 1'b0;
      out_ready <= 1'b0;
      note_done <= 1'b0;
    end else begin
      out_ready <= sample_tick;
      note_done <= sample_tick & done_d;
      if (sample_tick) begin
        phase_q <= phase_d;
        step_q  <= step_d;
        cnt_q   <= cnt_d;
        gate_q  <= gate;
        active  <= (phase_d != IDLE);
      end
    end
  end

  always_comb begin
    phase_d   = phase_q;
    step_d    = step_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    rise      = gate & ~gate_q;
    fall      = ~gate & gate_q;
    legal     = (phase_q <= RELEASE);
    last_step = R_LAST;

    case (phase_q)
      ATTACK:  last_step = A_LAST;
      DECAY:   last_step = D_LAST;
      default: last_step = R_LAST;
    endcase

    // Default per-phase behaviour (lowest priority).
    case (phase_q)
      IDLE, SUSTAIN: begin
        step_d = '0;
        cnt_d  = '0;
      end
      ATTACK, DECAY, RELEASE: begin
        if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = '0;
          if (step_q != last_step) begin
            step_d = step_q + 4'd1;
          end else begin
            step_d = '0;
            case (phase_q)
              ATTACK:  phase_d = DECAY;
              DECAY:   phase_d = SUSTAIN;
              default: begin
                phase_d = IDLE;
                done_d  = 1'b1;
              end
            endcase
          end
        end
      end
      default: begin
        // Corrupted encoding: fall back to IDLE quietly.
        phase_d = IDLE;
        step_d  = '0;
        cnt_d   = '0;
      end
    endcase

    // Gate edges override counting; rise is applied last so it wins.
    if (legal && fall && (phase_q inside {ATTACK, DECAY, SUSTAIN})) begin
      phase_d = RELEASE;
      step_d  = '0;
      cnt_d   = '0;
      done_d  = 1'b0;
    end
    if (legal && rise) begin
      phase_d = ATTACK;
      step_d  = '0;
      cnt_d   = '0;
      done_d  = 1'b0;
    end
  end

endmodule

// File: tb/tb_envelope_sequencer.sv
// tb/tb_envelope_sequencer.sv - scoreboard bench for envelope_sequencer
`timescale 1ns/1ps

module tb_envelope_sequencer;

  localparam int STEP_LEN = 4;
  localparam int A_STEPS  = 2;
  localparam int D_STEPS  = 2;
  localparam int R_STEPS  = 2;

  typedef struct packed {
    logic [2:0] ph;
    logic [3:0] st;
    logic       act;
    logic       done;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sample_tick = 1'b0;
  logic       gate = 1'b0;
  logic [2:0] phase;
  logic [3:0] step;
  logic       active;
  logic       out_ready;
  logic       note_done;

  int checks = 0;
  int failures = 0;

  exp_t exp_q[$];

  // Reference model state: phase and ticks elapsed within it.
  int m_ph = 0;
  int m_t = 0;
  int m_gq = 0;

  envelope_sequencer #(
    .STEP_LEN(STEP_LEN), .A_STEPS(A_STEPS), .D_STEPS(D_STEPS),
    .R_STEPS(R_STEPS), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .gate(gate),
    .phase(phase), .step(step), .active(active),
    .out_ready(out_ready), .note_done(note_done)
  );

  always #5 clk = ~clk;

  function automatic int dur(input int ph);
    case (ph)
      1:       return A_STEPS * STEP_LEN;
      2:       return D_STEPS * STEP_LEN;
      default: return R_STEPS * STEP_LEN;
    endcase
  endfunction

  task automatic model_tick(input int g);
    exp_t e;
    int   done;
    int   rise;
    int   fall;
    rise = (g == 1 && m_gq == 0) ? 1 : 0;
    fall = (g == 0 && m_gq == 1) ? 1 : 0;
    m_gq = g;
    done = 0;
    if (rise == 1) begin
      m_ph = 1; m_t = 0;
    end else if (fall == 1 && m_ph >= 1 && m_ph <= 3) begin
      m_ph = 4; m_t = 0;
    end else if (m_ph == 1 || m_ph == 2 || m_ph == 4) begin
      m_t = m_t + 1;
      if (m_t == dur(m_ph)) begin
        done = (m_ph == 4) ? 1 : 0;
        m_ph = (m_ph == 1) ? 2 : (m_ph == 2) ? 3 : 0;
        m_t = 0;
      end
    end
    e.ph   = 3'(m_ph);
    e.st   = (m_ph == 1 || m_ph == 2 || m_ph == 4) ? 4'(m_t / STEP_LEN) : 4'd0;
    e.act  = (m_ph != 0);
    e.done = (done == 1);
    exp_q.push_back(e);
  endtask

  // One sample tick after a random gap; gate is scrambled during the gap.
  task automatic do_tick(input int g);
    int gap;
    gap = $urandom_range(0, 2);
    for (int i = 0; i < gap; i++) begin
      sample_tick = 1'b0;
      gate = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    sample_tick = 1'b1;
    gate = 1'(g);
    model_tick(g);
    @(posedge clk); #1;
    sample_tick = 1'b0;
    gate = 1'(g);
  endtask

  task automatic run(input int g, input int n);
    for (int i = 0; i < n; i++) do_tick(g);
  endtask

  // Monitor: pops on every out_ready, otherwise demands held state.
  initial begin
    exp_t e;
    exp_t last_exp;
    logic prev_tick;
    last_exp = '0;
    prev_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_tick = 1'b0;
        last_exp = '0;
      end else begin
        checks++;
        if (out_ready !== prev_tick) begin
          failures++;
          $display("FAIL out_ready_align: got %b want %b at %0t", out_ready, prev_tick, $time);
        end
        if (out_ready === 1'b1) begin
          if (exp_q.size() == 0) begin
            e = last_exp;
            failures++;
            $display("FAIL unexpected_out_ready: no expected entry at %0t", $time);
          end else begin
            e = exp_q.pop_front();
            last_exp = e;
          end
        end else begin
          e = last_exp;
          e.done = 1'b0;
        end
        checks++;
        if ({phase, step, active, note_done} !== e) begin
          failures++;
          $display("FAIL %s: got ph=%0d st=%0d act=%b done=%b want ph=%0d st=%0d act=%b done=%b at %0t",
                   out_ready ? "tick_out" : "hold", phase, step, active, note_done,
                   e.ph, e.st, e.act, e.done, $time);
        end
        prev_tick = sample_tick;
      end
    end
  end

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL timeout: simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Full note: attack, decay, long sustain, release to idle.
    run(1, 66);
    run(0, 12);
    // Early release from ATTACK step 1.
    run(1, 5);
    run(0, 12);
    // Retrigger during RELEASE.
    run(1, 18);
    run(0, 2);
    run(1, 6);
    run(0, 12);

    // Reset while in DECAY; outputs must clear without a clock edge.
    run(1, 10);
    #1;
    checks++;
    if (phase !== 3'd2) begin
      failures++;
      $display("FAIL pre_reset_decay: got ph=%0d want 2", phase);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({phase, step, active} !== 8'd0) begin
      failures++;
      $display("FAIL async_reset: got ph=%0d st=%0d act=%b want 0 0 0", phase, step, active);
    end
    exp_q.delete();
    m_ph = 0; m_t = 0; m_gq = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    // Gate still high after reset: first tick is a rise.
    run(1, 20);
    run(0, 10);

    // Random gate runs.
    for (int n = 0; n < 60; n++) begin
      run(int'($urandom_range(0, 1)), int'($urandom_range(1, 12)));
    end
    run(0, 12);

    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
